// File: rtl/pong_ball_engine.sv
// pong_ball_engine: single-ball Pong physics for the local half of a two-screen
// game. Serves or accepts a ball, moves it once per frame, bounces it off the
// walls and the local paddle, and hands it to the remote side at the right edge.
module pong_ball_engine #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 10,
  parameter int VEL_W     = 4,
  parameter int PADDLE_X  = 10,
  parameter int PADDLE_W  = 4,
  parameter int PADDLE_H  = 60,
  parameter int SERVE_VX  = 2,
  parameter int SERVE_VY  = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             serve,
  input  logic [9:0]       paddle_y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_ball_y,
  input  logic [VEL_W-2:0] in_vel_x,
  input  logic [VEL_W-1:0] in_vel_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_ball_y,
  output logic [VEL_W-2:0] out_vel_x,
  output logic [VEL_W-1:0] out_vel_y,
  output logic [9:0]       ball_left,
  output logic [9:0]       ball_top,
  output logic             ball_visible,
  output logic             hit,
  output logic             miss
);

  typedef enum logic [1:0] {IDLE, PLAY, EXIT} state_t;

  localparam logic signed [10:0] LIMIT_BOTTOM = 11'(SCREEN_H - 1);
  localparam logic signed [10:0] LIMIT_RIGHT  = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] BALL_S       = 11'(BALL_SIZE);
  localparam logic signed [10:0] PADDLE_EDGE  = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0]        BALL_SPAN    = 11'(BALL_SIZE - 1);
  localparam logic [10:0]        PADDLE_SPAN  = 11'(PADDLE_H - 1);
  localparam logic [9:0]         TOP_FLOOR    = 10'(SCREEN_H - 1 - BALL_SIZE);
  localparam logic [9:0]         ENTRY_LEFT   = 10'(SCREEN_W - 1 - BALL_SIZE);
  localparam logic [9:0]         CENTER_LEFT  = 10'(SCREEN_W / 2);
  localparam logic [9:0]         CENTER_TOP   = 10'(SCREEN_H / 2);
  localparam logic [9:0]         HIT_LEFT     = 10'(PADDLE_X + PADDLE_W + 1);
  localparam logic [VEL_W-1:0]   SERVE_VX_V   = VEL_W'(SERVE_VX);
  localparam logic [VEL_W-1:0]   SERVE_VY_V   = VEL_W'(SERVE_VY);
  localparam logic [VEL_W-1:0]   VEL_MIN      = {1'b1, {(VEL_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [9:0]              ballLeft_q, ballLeft_d;
  logic [9:0]              ballTop_q, ballTop_d;
  logic signed [VEL_W-1:0] vx_q, vx_d;
  logic signed [VEL_W-1:0] vy_q, vy_d;
  logic [8:0]              outY_q, outY_d;
  logic [VEL_W-2:0]        outVx_q, outVx_d;
  logic [VEL_W-1:0]        outVy_q, outVy_d;
  logic                    hit_q, hit_d;
  logic                    miss_q, miss_d;

  logic signed [10:0]      candLeft;
  logic signed [10:0]      candTop;
  logic [9:0]              newTop;
  logic signed [VEL_W-1:0] newVy;
  logic                    overlap;
  logic signed [VEL_W-1:0] absVx;
  logic signed [VEL_W-1:0] inMag;

  function automatic logic signed [VEL_W-1:0] negSat(input logic signed [VEL_W-1:0] v);
    if (v == VEL_MIN) negSat = ~VEL_MIN;
    else              negSat = -v;
  endfunction

  // Next-state logic: serve/accept in IDLE, per-frame physics in PLAY, hand-off in EXIT
  always_comb begin
    state_d    = state_q;
    ballLeft_d = ballLeft_q;
    ballTop_d  = ballTop_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    outY_d     = outY_q;
    outVx_d    = outVx_q;
    outVy_d    = outVy_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    candLeft = $signed({1'b0, ballLeft_q}) + $signed({{(11-VEL_W){vx_q[VEL_W-1]}}, vx_q});
    candTop  = $signed({1'b0, ballTop_q})  + $signed({{(11-VEL_W){vy_q[VEL_W-1]}}, vy_q});

    newTop = ballTop_q;
    newVy  = vy_q;
    if (candTop <= 11'sd0) begin
      newTop = '0;
      newVy  = negSat(vy_q);
    end else if (candTop + BALL_S >= LIMIT_BOTTOM) begin
      newTop = TOP_FLOOR;
      newVy  = negSat(vy_q);
    end else begin
      newTop = candTop[9:0];
    end

    overlap = ({1'b0, newTop} <= {1'b0, paddle_y} + PADDLE_SPAN) &&
              ({1'b0, newTop} + BALL_SPAN >= {1'b0, paddle_y});

    absVx = vx_q[VEL_W-1] ? negSat(vx_q) : vx_q;
    inMag = {1'b0, in_vel_x};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = PLAY;
          ballLeft_d = ENTRY_LEFT;
          ballTop_d  = {1'b0, in_ball_y};
          vx_d       = -inMag;
          vy_d       = in_vel_y;
        end else if (serve) begin
          state_d    = PLAY;
          ballLeft_d = CENTER_LEFT;
          ballTop_d  = CENTER_TOP;
          vx_d       = SERVE_VX_V;
          vy_d       = SERVE_VY_V;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (vx_q[VEL_W-1] && (candLeft <= PADDLE_EDGE) && overlap) begin
            ballLeft_d = HIT_LEFT;
            ballTop_d  = newTop;
            vx_d       = negSat(vx_q);
            vy_d       = newVy;
            hit_d      = 1'b1;
          end else if (vx_q[VEL_W-1] && (candLeft <= 11'sd0)) begin
            state_d = IDLE;
            miss_d  = 1'b1;
          end else if (candLeft + BALL_S >= LIMIT_RIGHT) begin
            state_d    = EXIT;
            ballLeft_d = candLeft[9:0];
            ballTop_d  = newTop;
            vy_d       = newVy;
            outY_d     = newTop[8:0];
            outVx_d    = absVx[VEL_W-2:0] | {(VEL_W-1){absVx[VEL_W-1]}};
            outVy_d    = newVy;
          end else begin
            ballLeft_d = candLeft[9:0];
            ballTop_d  = newTop;
            vy_d       = newVy;
          end
        end
      end
      EXIT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset recentres the ball and drops any pending hand-off
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ballLeft_q <= CENTER_LEFT;
      ballTop_q  <= CENTER_TOP;
      vx_q       <= '0;
      vy_q       <= '0;
      outY_q     <= '0;
      outVx_q    <= '0;
      outVy_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ballLeft_q <= ballLeft_d;
      ballTop_q  <= ballTop_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      outY_q     <= outY_d;
      outVx_q    <= outVx_d;
      outVy_q    <= outVy_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == EXIT);
  assign ball_visible = (state_q == PLAY);
  assign ball_left    = ballLeft_q;
  assign ball_top     = ballTop_q;
  assign out_ball_y   = outY_q;
  assign out_vel_x    = outVx_q;
  assign out_vel_y    = outVy_q;
  assign hit          = hit_q;
  assign miss         = miss_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed scenarios plus random play, every cycle compared
// against a plain-arithmetic model of the ball's rules.
module tb_pong_ball_engine;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_SIZE = 10;
  localparam int VEL_W     = 4;
  localparam int PADDLE_X  = 10;
  localparam int PADDLE_W  = 4;
  localparam int PADDLE_H  = 60;
  localparam int SERVE_VX  = 2;
  localparam int SERVE_VY  = 1;

  logic             CLOCK_50 = 1'b0;
  logic             reset = 1'b0;
  logic             frame_tick = 1'b0;
  logic             serve = 1'b0;
  logic [9:0]       paddle_y = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8:0]       in_ball_y = '0;
  logic [VEL_W-2:0] in_vel_x = '0;
  logic [VEL_W-1:0] in_vel_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [8:0]       out_ball_y;
  logic [VEL_W-2:0] out_vel_x;
  logic [VEL_W-1:0] out_vel_y;
  logic [9:0]       ball_left;
  logic [9:0]       ball_top;
  logic             ball_visible;
  logic             hit;
  logic             miss;

  int testsRun = 0;
  int testsFailed = 0;

  int mLeft, mTop, mVx, mVy, mOutY, mOutVx, mOutVy;
  bit mOnScreen, mLeaving, mHit, mMiss;

  pong_ball_engine dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .serve       (serve),
    .paddle_y    (paddle_y),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ball_y   (in_ball_y),
    .in_vel_x    (in_vel_x),
    .in_vel_y    (in_vel_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ball_y  (out_ball_y),
    .out_vel_x   (out_vel_x),
    .out_vel_y   (out_vel_y),
    .ball_left   (ball_left),
    .ball_top    (ball_top),
    .ball_visible(ball_visible),
    .hit         (hit),
    .miss        (miss)
  );

  // 50 MHz system clock
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int negSat(input int v);
    int vmin;
    vmin = -(1 << (VEL_W - 1));
    return (v == vmin) ? (-vmin - 1) : -v;
  endfunction

  function automatic int toSigned(input logic [VEL_W-1:0] v);
    int r;
    r = int'(v);
    if (r >= (1 << (VEL_W - 1))) r = r - (1 << VEL_W);
    return r;
  endfunction

  function automatic void modelReset();
    mOnScreen = 0; mLeaving = 0;
    mLeft = SCREEN_W / 2; mTop = SCREEN_H / 2;
    mVx = 0; mVy = 0;
    mOutY = 0; mOutVx = 0; mOutVy = 0;
    mHit = 0; mMiss = 0;
  endfunction

  function automatic void modelStep();
    int cl, ct, nt, nvy;
    bit rowsMeet;
    mHit = 0; mMiss = 0;
    if (mLeaving) begin
      if (out_ready) mLeaving = 0;
    end else if (!mOnScreen) begin
      if (in_valid) begin
        mOnScreen = 1;
        mLeft = SCREEN_W - 1 - BALL_SIZE;
        mTop = int'(in_ball_y);
        mVx = -int'(in_vel_x);
        mVy = toSigned(in_vel_y);
      end else if (serve) begin
        mOnScreen = 1;
        mLeft = SCREEN_W / 2; mTop = SCREEN_H / 2;
        mVx = SERVE_VX; mVy = SERVE_VY;
      end
    end else if (frame_tick) begin
      cl = mLeft + mVx;
      ct = mTop + mVy;
      if (ct <= 0) begin
        nt = 0; nvy = negSat(mVy);
      end else if (ct + BALL_SIZE >= SCREEN_H - 1) begin
        nt = SCREEN_H - 1 - BALL_SIZE; nvy = negSat(mVy);
      end else begin
        nt = ct; nvy = mVy;
      end
      rowsMeet = (nt <= int'(paddle_y) + PADDLE_H - 1) && (nt + BALL_SIZE - 1 >= int'(paddle_y));
      if (mVx < 0 && cl <= PADDLE_X + PADDLE_W && rowsMeet) begin
        mLeft = PADDLE_X + PADDLE_W + 1; mTop = nt;
        mVx = negSat(mVx); mVy = nvy; mHit = 1;
      end else if (mVx < 0 && cl <= 0) begin
        mOnScreen = 0; mMiss = 1;
      end else if (cl + BALL_SIZE >= SCREEN_W - 1) begin
        mOnScreen = 0; mLeaving = 1;
        mLeft = cl; mTop = nt; mVy = nvy;
        mOutY = nt % 512;
        mOutVx = (mVx < 0) ? negSat(mVx) : mVx;
        mOutVy = nvy;
      end else begin
        mLeft = cl; mTop = nt; mVy = nvy;
      end
    end
  endfunction

  task automatic compareModel(input string phase);
    checkOutput({phase, ".ball_left"}, ball_left, mLeft);
    checkOutput({phase, ".ball_top"}, ball_top, mTop);
    checkOutput({phase, ".ball_visible"}, ball_visible, mOnScreen);
    checkOutput({phase, ".in_ready"}, in_ready, !(mOnScreen || mLeaving));
    checkOutput({phase, ".out_valid"}, out_valid, mLeaving);
    checkOutput({phase, ".hit"}, hit, mHit);
    checkOutput({phase, ".miss"}, miss, mMiss);
    checkOutput({phase, ".out_ball_y"}, out_ball_y, mOutY);
    checkOutput({phase, ".out_vel_x"}, out_vel_x, mOutVx);
    checkOutput({phase, ".out_vel_y"}, out_vel_y, mOutVy & ((1 << VEL_W) - 1));
  endtask

  task automatic applyStimulus(input string phase);
    @(posedge CLOCK_50);
    modelStep();
    #1;
    compareModel(phase);
  endtask

  task automatic doReset(input string phase);
    reset = 1'b1;
    #1;
    modelReset();
    compareModel(phase);
    checkOutput({phase, ".rst_left"}, ball_left, 320);
    checkOutput({phase, ".rst_top"}, ball_top, 240);
    checkOutput({phase, ".rst_visible"}, ball_visible, 0);
    checkOutput({phase, ".rst_out_valid"}, out_valid, 0);
    #2;
    reset = 1'b0;
  endtask

  task automatic tick(input string phase);
    frame_tick = 1'b1;
    applyStimulus(phase);
    frame_tick = 1'b0;
    applyStimulus(phase);
  endtask

  task automatic inject(input int y, input int vx, input int vy);
    in_valid = 1'b1;
    in_ball_y = 9'(y);
    in_vel_x = (VEL_W-1)'(vx);
    in_vel_y = VEL_W'(vy);
    applyStimulus("inject");
    in_valid = 1'b0;
  endtask

  initial begin
    int missCount;

    doReset("por");

    // Serve then three frames
    serve = 1'b1;
    applyStimulus("serve");
    serve = 1'b0;
    checkOutput("serve.visible", ball_visible, 1);
    repeat (3) tick("serve.move");
    checkOutput("serve3.left", ball_left, 326);
    checkOutput("serve3.top", ball_top, 243);

    // Top wall bounce
    doReset("r28");
    inject(1, 1, -2);
    tick("r28");
    checkOutput("r28.top0", ball_top, 0);
    tick("r28");
    checkOutput("r28.top2", ball_top, 2);

    // Most negative vertical speed saturates when reflected
    doReset("r22");
    inject(5, 1, -8);
    tick("r22");
    checkOutput("r22.top0", ball_top, 0);
    tick("r22");
    checkOutput("r22.top7", ball_top, 7);

    // Paddle hit
    doReset("r29");
    paddle_y = 10'd400;
    inject(200, 2, 0);
    repeat (307) tick("r29.approach");
    checkOutput("r29.left_before", ball_left, 15);
    paddle_y = 10'd195;
    frame_tick = 1'b1;
    applyStimulus("r29.hit");
    frame_tick = 1'b0;
    checkOutput("r29.hit_left", ball_left, 15);
    checkOutput("r29.hit_pulse", hit, 1);
    applyStimulus("r29.after");
    checkOutput("r29.hit_clear", hit, 0);
    tick("r29.return");
    checkOutput("r29.return_left", ball_left, 17);

    // Paddle out of the way: ball walks to the left edge and is missed
    doReset("r30");
    paddle_y = 10'd400;
    inject(200, 2, 0);
    repeat (308) tick("r30.approach");
    checkOutput("r30.left13", ball_left, 13);
    missCount = 0;
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1;
      applyStimulus("r30.walk");
      if (miss === 1'b1) missCount++;
      frame_tick = 1'b0;
      applyStimulus("r30.walk");
      if (miss === 1'b1) missCount++;
    end
    checkOutput("r30.miss_count", missCount, 1);
    checkOutput("r30.idle", in_ready, 1);
    checkOutput("r30.hidden", ball_visible, 0);
    checkOutput("r30.frozen_left", ball_left, 1);

    // Return across the screen and hand off with the sender stalled
    doReset("r31");
    inject(200, 2, -3);
    for (int i = 0; i < 800 && !mLeaving; i++) begin
      paddle_y = (mTop > 5) ? 10'(mTop - 5) : 10'd0;
      tick("r31.rally");
    end
    checkOutput("r31.exit", out_valid, 1);
    checkOutput("r31.vel_x", out_vel_x, 2);
    checkOutput("r31.vel_y_mag", (out_vel_y == 4'd3 || out_vel_y == 4'd13), 1);
    serve = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'(i % 2);
      applyStimulus("r31.hold");
      checkOutput("r31.hold_valid", out_valid, 1);
    end
    serve = 1'b0;
    in_valid = 1'b0;
    frame_tick = 1'b0;
    out_ready = 1'b1;
    applyStimulus("r31.release");
    out_ready = 1'b0;
    checkOutput("r31.idle", in_ready, 1);
    checkOutput("r31.valid_low", out_valid, 0);

    // Incoming ball wins over a simultaneous serve, then reset mid-play
    doReset("r32");
    serve = 1'b1;
    in_valid = 1'b1;
    in_ball_y = 9'd100;
    in_vel_x = 3'd3;
    in_vel_y = 4'd1;
    applyStimulus("r32.accept");
    serve = 1'b0;
    in_valid = 1'b0;
    checkOutput("r32.left", ball_left, 629);
    checkOutput("r32.top", ball_top, 100);
    tick("r32.move");
    checkOutput("r32.left_moved", ball_left, 626);
    doReset("r32.midplay");

    // Random play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset("rnd.reset");
      end else begin
        frame_tick = 1'($urandom_range(0, 1));
        serve = ($urandom_range(0, 7) == 0);
        in_valid = ($urandom_range(0, 9) == 0);
        in_ball_y = 9'($urandom_range(0, 511));
        in_vel_x = 3'($urandom_range(0, 7));
        in_vel_y = 4'($urandom_range(0, 15));
        out_ready = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 0)
          paddle_y = (mTop > 20) ? 10'(mTop - 20) : 10'd0;
        else if ($urandom_range(0, 15) == 0)
          paddle_y = 10'($urandom_range(0, 479));
        applyStimulus("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
